mm_tile_sequencer: RTL and testbench

- Tile-level controller for the matrix-multiply coprocessor datapath.
- Accepts one multi-tile job command and drives the work_mode/address controls of the reshape_in → systolic → reshape_out chain: per tile, a WEIGHT phase, then a COMPUTE phase that ends at writeback completion.
- Arbitrates the shared SRAM port between host (PCPI) load/read accesses and the running job; host access is allowed only while idle or in the inter-tile gap.
- Detects hung phases via a timeout.

---
 rtl/mm_tile_sequencer_pkg.sv | 31 +++
 rtl/mm_tile_sequencer_if.sv | 41 ++++
 rtl/mm_tile_sequencer_phase_timer.sv | 30 +++
 rtl/mm_tile_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mm_tile_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_tile_sequencer_pkg.sv
// rtl/mm_tile_sequencer_pkg.sv - shared encodings and defaults for the tile sequencer
package mm_tile_sequencer_pkg;

  localparam int SEQ_AWIDTH      = 10;
  localparam int SEQ_TILE_WORDS  = 16;
  localparam int SEQ_NT_W        = 8;
  localparam int SEQ_TIMEOUT_CYC = 1024;

  localparam logic [1:0] WM_IDLE    = 2'b00;
  localparam logic [1:0] WM_LOAD    = 2'b01;
  localparam logic [1:0] WM_WEIGHT  = 2'b10;
  localparam logic [1:0] WM_COMPUTE = 2'b11;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE    = 3'd0;
  localparam seq_state_t ST_WEIGHT  = 3'd1;
  localparam seq_state_t ST_COMPUTE = 3'd2;
  localparam seq_state_t ST_GAP     = 3'd3;
  localparam seq_state_t ST_DONE    = 3'd4;
  localparam seq_state_t ST_ERR     = 3'd5;

  function automatic logic [1:0] mode_of(seq_state_t s);
    case (s)
      ST_WEIGHT:  return WM_WEIGHT;
      ST_COMPUTE: return WM_COMPUTE;
      default:    return WM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mm_tile_sequencer_if.sv
// rtl/mm_tile_sequencer_if.sv - job command, host arbitration and datapath control bundle
interface mm_tile_sequencer_if
  import mm_tile_sequencer_pkg::*;
#(
  parameter int AWIDTH = SEQ_AWIDTH,
  parameter int NT_W   = SEQ_NT_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [AWIDTH-1:0] cmd_wbase;
  logic [AWIDTH-1:0] cmd_abase;
  logic [AWIDTH-1:0] cmd_rbase;
  logic [NT_W-1:0]   cmd_ntiles;
  logic              host_req;
  logic              host_gnt;
  logic [1:0]        work_mode;
  logic [AWIDTH-1:0] rd_base;
  logic [AWIDTH-1:0] wb_base;
  logic              weight_done;
  logic              wb_done;
  logic              busy;
  logic              done;
  logic              err;
  logic [NT_W-1:0]   tile_idx;

  modport slave (
    input  cmd_valid, cmd_wbase, cmd_abase, cmd_rbase, cmd_ntiles,
    input  host_req, weight_done, wb_done,
    output cmd_ready, host_gnt, work_mode, rd_base, wb_base,
    output busy, done, err, tile_idx
  );

  modport master (
    output cmd_valid, cmd_wbase, cmd_abase, cmd_rbase, cmd_ntiles,
    output host_req, weight_done, wb_done,
    input  cmd_ready, host_gnt, work_mode, rd_base, wb_base,
    input  busy, done, err, tile_idx
  );

endinterface

// File: rtl/mm_tile_sequencer_phase_timer.sv
// rtl/mm_tile_sequencer_phase_timer.sv - loadable phase cycle counter with expiry flag
module mm_phase_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  // Loading to 1 makes the count equal the number of cycles spent in the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(1);
    end else if (run_i && cnt_q != LIM) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LIM);

endmodule

// File: rtl/mm_tile_sequencer.sv
// rtl/mm_tile_sequencer.sv - multi-tile job sequencer for the matrix-multiply datapath
// Optional performance counters enabled by MM_SEQ_PERF_CNT_EN.
module mm_tile_sequencer
  import mm_tile_sequencer_pkg::*;
#(
  parameter int AWIDTH      = SEQ_AWIDTH,
  parameter int TILE_WORDS  = SEQ_TILE_WORDS,
  parameter int NT_W        = SEQ_NT_W,
  parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  mm_tile_sequencer_if.slave bus
`ifdef MM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_busy_cyc,
  output logic [31:0]        perf_host_cyc
`endif
);

  seq_state_t        state_q, state_d;
  logic [AWIDTH-1:0] wbase_q, wbase_d, abase_q, abase_d, rbase_q, rbase_d;
  logic [NT_W-1:0]   ntiles_q, ntiles_d, tile_q, tile_d;
  logic [AWIDTH-1:0] rd_base_q, rd_base_d, wb_base_q, wb_base_d;
  logic [AWIDTH-1:0] tile_off;
  logic [1:0]        wm_q, wm_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              host_gnt_q, host_gnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              accept, timer_load, timer_run, timer_expired;

  // A host request arriving alongside a command wins even if ready was already high.
  assign accept = (state_q == ST_IDLE) && bus.cmd_valid && cmd_ready_q && !bus.host_req;

  always_comb begin
    state_d  = state_q;
    wbase_d  = wbase_q;
    abase_d  = abase_q;
    rbase_d  = rbase_q;
    ntiles_d = ntiles_q;
    tile_d   = tile_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wbase_d  = bus.cmd_wbase;
          abase_d  = bus.cmd_abase;
          rbase_d  = bus.cmd_rbase;
          ntiles_d = bus.cmd_ntiles;
          tile_d   = '0;
          state_d  = (bus.cmd_ntiles == '0) ? ST_DONE : ST_WEIGHT;
        end
      end
      ST_WEIGHT: begin
        if (bus.weight_done)    state_d = ST_COMPUTE;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_COMPUTE: begin
        if (bus.wb_done)        state_d = ST_GAP;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_GAP: begin
        // Stay while the host holds the port, plus one ungranted cycle after release.
        if (!(bus.host_req || host_gnt_q)) begin
          tile_d  = tile_q + 1'b1;
          state_d = (tile_d == ntiles_q) ? ST_DONE : ST_WEIGHT;
        end
      end
      ST_ERR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tile_off  = AWIDTH'(32'(tile_d) * TILE_WORDS);
    wm_d      = mode_of(state_d);
    rd_base_d = rd_base_q;
    wb_base_d = wb_base_q;
    if (state_d == ST_WEIGHT) begin
      rd_base_d = wbase_d + tile_off;
    end else if (state_d == ST_COMPUTE) begin
      rd_base_d = abase_d + tile_off;
      wb_base_d = rbase_d + tile_off;
    end
    // The done pulse appears the cycle after DONE, so busy is extended to cover it.
    busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
    done_d      = (state_q == ST_DONE);
    err_d       = accept ? 1'b0 : ((state_d == ST_ERR) ? 1'b1 : err_q);
    host_gnt_d  = bus.host_req &&
                  ((state_d == ST_GAP) || (state_q == ST_IDLE && state_d == ST_IDLE));
    cmd_ready_d = (state_d == ST_IDLE) && !busy_d && !bus.host_req;
  end

  assign timer_load = ((state_d == ST_WEIGHT)  && (state_q != ST_WEIGHT)) ||
                      ((state_d == ST_COMPUTE) && (state_q != ST_COMPUTE));
  assign timer_run  = (state_q == ST_WEIGHT) || (state_q == ST_COMPUTE);

  mm_phase_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .run_i     (timer_run),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wbase_q     <= '0;
      abase_q     <= '0;
      rbase_q     <= '0;
      ntiles_q    <= '0;
      tile_q      <= '0;
      rd_base_q   <= '0;
      wb_base_q   <= '0;
      wm_q        <= WM_IDLE;
      cmd_ready_q <= 1'b0;
      host_gnt_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbase_q     <= wbase_d;
      abase_q     <= abase_d;
      rbase_q     <= rbase_d;
      ntiles_q    <= ntiles_d;
      tile_q      <= tile_d;
      rd_base_q   <= rd_base_d;
      wb_base_q   <= wb_base_d;
      wm_q        <= wm_d;
      cmd_ready_q <= cmd_ready_d;
      host_gnt_q  <= host_gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.host_gnt  = host_gnt_q;
  assign bus.work_mode = wm_q;
  assign bus.rd_base   = rd_base_q;
  assign bus.wb_base   = wb_base_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tile_idx  = tile_q;

`ifdef MM_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_host_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_busy_q <= '0;
      perf_host_q <= '0;
    end else begin
      if (busy_q && perf_busy_q != '1)
        perf_busy_q <= perf_busy_q + 1'b1;
      if (host_gnt_q && state_q == ST_GAP && perf_host_q != '1)
        perf_host_q <= perf_host_q + 1'b1;
    end
  end

  assign perf_busy_cyc = perf_busy_q;
  assign perf_host_cyc = perf_host_q;
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb/tb_mm_tile_sequencer.sv - directed self-checking bench for mm_tile_sequencer
module tb_mm_tile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  int   viol = 0;

  mm_tile_sequencer_if #(.AWIDTH(10), .NT_W(8)) bus ();

`ifdef MM_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_cyc, perf_host_cyc;
`endif

  mm_tile_sequencer #(
    .AWIDTH(10), .TILE_WORDS(16), .NT_W(8), .TIMEOUT_CYC(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MM_SEQ_PERF_CNT_EN
    ,
    .perf_busy_cyc (perf_busy_cyc),
    .perf_host_cyc (perf_host_cyc)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.host_gnt === 1'b1 && bus.work_mode !== 2'b00) viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [9:0] w, input logic [9:0] a, input logic [9:0] r,
                          input logic [7:0] n);
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 50) begin step(); k++; end
    n_total++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL cmd_ready_wait: got %b expected 1", bus.cmd_ready);
    else n_pass++;
    bus.cmd_wbase = w; bus.cmd_abase = a; bus.cmd_rbase = r; bus.cmd_ntiles = n;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (bus.done !== 1'b1 && k < 20) begin step(); k++; end
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL %s: got done=%b expected 1", name, bus.done);
    else n_pass++;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    n_total++;
    if ({bus.cmd_ready, bus.host_gnt, bus.work_mode, bus.busy, bus.done, bus.err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {bus.cmd_ready, bus.host_gnt, bus.work_mode, bus.busy, bus.done, bus.err});
    else n_pass++;
    n_total++;
    if ({bus.rd_base, bus.wb_base, bus.tile_idx} !== 28'h0)
      $display("FAIL reset_addr: got %h expected 0", {bus.rd_base, bus.wb_base, bus.tile_idx});
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_two_tiles();
    int d0 = done_cnt;
    send_cmd(10'h000, 10'h100, 10'h200, 8'd2);
    n_total++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
      $display("FAIL tt_busy: got busy=%b ready=%b expected busy=1 ready=0", bus.busy, bus.cmd_ready);
    else n_pass++;
    for (int t = 0; t < 2; t++) begin
      n_total++;
      if (bus.work_mode !== 2'b10 || bus.rd_base !== 10'(t * 16) || bus.tile_idx !== 8'(t))
        $display("FAIL tt_weight t%0d: got wm=%b rd=%h tile=%0d expected wm=10 rd=%h tile=%0d",
                 t, bus.work_mode, bus.rd_base, bus.tile_idx, t * 16, t);
      else n_pass++;
      step(); bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0; step(); step();
      n_total++;
      if (bus.work_mode !== 2'b10)
        $display("FAIL tt_wb_ignored t%0d: got wm=%b expected 10", t, bus.work_mode);
      else n_pass++;
      bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
      n_total++;
      if (bus.work_mode !== 2'b11 || bus.rd_base !== 10'(256 + t * 16) || bus.wb_base !== 10'(512 + t * 16))
        $display("FAIL tt_compute t%0d: got wm=%b rd=%h wb=%h expected wm=11 rd=%h wb=%h",
                 t, bus.work_mode, bus.rd_base, bus.wb_base, 256 + t * 16, 512 + t * 16);
      else n_pass++;
      step(); bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
      repeat (17) step();
      n_total++;
      if (bus.work_mode !== 2'b11)
        $display("FAIL tt_wd_ignored t%0d: got wm=%b expected 11", t, bus.work_mode);
      else n_pass++;
      bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
      n_total++;
      if (bus.work_mode !== 2'b00 || bus.done !== 1'b0)
        $display("FAIL tt_gap t%0d: got wm=%b done=%b expected wm=00 done=0", t, bus.work_mode, bus.done);
      else n_pass++;
      step();
    end
    wait_done("tt_done");
    step();
    n_total++;
    if (done_cnt - d0 !== 1 || bus.err !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL tt_end: got pulses=%0d err=%b busy=%b expected pulses=1 err=0 busy=0",
               done_cnt - d0, bus.err, bus.busy);
    else n_pass++;
  endtask

  task automatic test_zero_tiles();
    send_cmd(10'h000, 10'h000, 10'h000, 8'd0);
    n_total++;
    if (bus.done !== 1'b0 || bus.work_mode !== 2'b00 || bus.busy !== 1'b1)
      $display("FAIL zt_c1: got done=%b wm=%b busy=%b expected 0 00 1", bus.done, bus.work_mode, bus.busy);
    else n_pass++;
    step();
    n_total++;
    if (bus.done !== 1'b1 || bus.work_mode !== 2'b00)
      $display("FAIL zt_c2: got done=%b wm=%b expected 1 00", bus.done, bus.work_mode);
    else n_pass++;
    step();
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL zt_c3: got done=%b busy=%b ready=%b expected 0 0 1", bus.done, bus.busy, bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_host_gap();
    int gcnt = 0;
    send_cmd(10'h000, 10'h100, 10'h200, 8'd2);
    bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
    step(); step();
    bus.host_req = 1'b1; bus.wb_done = 1'b1;
    n_total++;
    if (bus.host_gnt !== 1'b0 || bus.work_mode !== 2'b11)
      $display("FAIL hg_compute: got gnt=%b wm=%b expected 0 11", bus.host_gnt, bus.work_mode);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) bus.wb_done = 1'b0;
      if (bus.host_gnt === 1'b1 && bus.work_mode === 2'b00) gcnt++;
    end
    bus.host_req = 1'b0;
    n_total++;
    if (gcnt !== 10) $display("FAIL hg_gnt_cycles: got %0d expected 10", gcnt);
    else n_pass++;
    step();
    n_total++;
    if (bus.host_gnt !== 1'b0 || bus.work_mode !== 2'b00)
      $display("FAIL hg_release: got gnt=%b wm=%b expected 0 00", bus.host_gnt, bus.work_mode);
    else n_pass++;
    step();
    n_total++;
    if (bus.work_mode !== 2'b10 || bus.rd_base !== 10'h010 || bus.tile_idx !== 8'd1)
      $display("FAIL hg_tile1: got wm=%b rd=%h tile=%0d expected 10 010 1", bus.work_mode, bus.rd_base, bus.tile_idx);
    else n_pass++;
    bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
    bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
    wait_done("hg_done");
  endtask

  task automatic test_idle_priority();
    n_total++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL ip_ready_pre: got %b expected 1", bus.cmd_ready);
    else n_pass++;
    bus.cmd_wbase = 10'h020; bus.cmd_abase = 10'h040; bus.cmd_rbase = 10'h060; bus.cmd_ntiles = 8'd1;
    bus.cmd_valid = 1'b1; bus.host_req = 1'b1;
    step();
    n_total++;
    if (bus.host_gnt !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL ip_host_wins: got gnt=%b ready=%b busy=%b expected 1 0 0", bus.host_gnt, bus.cmd_ready, bus.busy);
    else n_pass++;
    step(); step();
    bus.host_req = 1'b0;
    step();
    n_total++;
    if (bus.cmd_ready !== 1'b1 || bus.host_gnt !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL ip_after_drop: got ready=%b gnt=%b busy=%b expected 1 0 0", bus.cmd_ready, bus.host_gnt, bus.busy);
    else n_pass++;
    step();
    bus.cmd_valid = 1'b0;
    n_total++;
    if (bus.busy !== 1'b1 || bus.work_mode !== 2'b10 || bus.rd_base !== 10'h020)
      $display("FAIL ip_accept: got busy=%b wm=%b rd=%h expected 1 10 020", bus.busy, bus.work_mode, bus.rd_base);
    else n_pass++;
    bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
    bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
    wait_done("ip_done");
  endtask

  task automatic test_timeout();
    send_cmd(10'h040, 10'h080, 10'h0C0, 8'd1);
    repeat (1023) step();
    n_total++;
    if (bus.work_mode !== 2'b10 || bus.err !== 1'b0)
      $display("FAIL to_last_weight: got wm=%b err=%b expected 10 0", bus.work_mode, bus.err);
    else n_pass++;
    step();
    n_total++;
    if (bus.err !== 1'b1 || bus.work_mode !== 2'b00 || bus.busy !== 1'b1)
      $display("FAIL to_err: got err=%b wm=%b busy=%b expected 1 00 1", bus.err, bus.work_mode, bus.busy);
    else n_pass++;
    step(); step();
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL to_done: got %b expected 1", bus.done);
    else n_pass++;
    step();
    n_total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL to_sticky: got err=%b busy=%b expected 1 0", bus.err, bus.busy);
    else n_pass++;
    send_cmd(10'h000, 10'h000, 10'h000, 8'd0);
    n_total++;
    if (bus.err !== 1'b0) $display("FAIL to_clear: got err=%b expected 0", bus.err);
    else n_pass++;
    wait_done("to_next_done");
  endtask

  task automatic test_wrap_and_reset();
    int d0;
    send_cmd(10'h3F8, 10'h010, 10'h020, 8'd2);
    n_total++;
    if (bus.rd_base !== 10'h3F8) $display("FAIL wr_t0_weight: got %h expected 3f8", bus.rd_base);
    else n_pass++;
    bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
    bus.wb_done = 1'b1; step(); bus.wb_done = 1'b0;
    step();
    n_total++;
    if (bus.rd_base !== 10'h008 || bus.work_mode !== 2'b10)
      $display("FAIL wr_t1_weight: got rd=%h wm=%b expected 008 10", bus.rd_base, bus.work_mode);
    else n_pass++;
    bus.weight_done = 1'b1; step(); bus.weight_done = 1'b0;
    n_total++;
    if (bus.rd_base !== 10'h020 || bus.wb_base !== 10'h030 || bus.work_mode !== 2'b11)
      $display("FAIL wr_t1_compute: got rd=%h wb=%h wm=%b expected 020 030 11", bus.rd_base, bus.wb_base, bus.work_mode);
    else n_pass++;
    d0 = done_cnt;
    rst = 1'b1;
    step();
    n_total++;
    if ({bus.cmd_ready, bus.host_gnt, bus.work_mode, bus.busy, bus.done, bus.err} !== 7'b0 ||
        {bus.rd_base, bus.wb_base, bus.tile_idx} !== 28'h0)
      $display("FAIL wr_mid_reset: got ctrl=%b addr=%h expected 0 0",
               {bus.cmd_ready, bus.host_gnt, bus.work_mode, bus.busy, bus.done, bus.err},
               {bus.rd_base, bus.wb_base, bus.tile_idx});
    else n_pass++;
    step();
    rst = 1'b0;
    repeat (3) step();
    n_total++;
    if (done_cnt !== d0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL wr_no_done: got pulses=%0d ready=%b busy=%b expected 0 1 0",
               done_cnt - d0, bus.cmd_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_invariants();
    n_total++;
    if (viol !== 0) $display("FAIL gnt_vs_mode: got %0d overlapping cycles expected 0", viol);
    else n_pass++;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_wbase = '0; bus.cmd_abase = '0; bus.cmd_rbase = '0;
    bus.cmd_ntiles = '0; bus.host_req = 1'b0; bus.weight_done = 1'b0; bus.wb_done = 1'b0;
    test_reset();
    test_two_tiles();
    test_zero_tiles();
    test_host_gap();
    test_idle_priority();
    test_timeout();
    test_wrap_and_reset();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
